// File: rtl/hdmi_frame_pkg.sv
// Shared definitions for the HDMI frame-buffer read and write request generators.
// Holds the buffer index width, the request FSM encoding and the default ack timeout.
package hdmi_frame_pkg;

  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] buf_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_READING = 2'd2
  } frm_state_e;

  localparam logic [15:0] ACK_TIMEOUT_DEF = 16'd4096;

endpackage

// File: rtl/vsync_edge_det.sv
// Rising-edge detector for an already-synchronous vsync level.
// rise is high for one cycle, the cycle after the edge that first samples vsync=1.
module vsync_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic vsync,
  output logic rise
);

  logic vs_d0_q, vs_d0_d;
  logic vs_d1_q, vs_d1_d;

  always_comb begin
    vs_d0_d = vsync;
    vs_d1_d = vs_d0_q;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_d0_q <= 1'b0;
      vs_d1_q <= 1'b0;
    end else begin
      vs_d0_q <= vs_d0_d;
      vs_d1_q <= vs_d1_d;
    end
  end

  assign rise = vs_d0_q & ~vs_d1_q;

endmodule

// File: rtl/hdmi_read_req_gen.sv
// Issues one frame-read request per display vsync, choosing the most recently completed buffer.
// read_req rises 2 cycles after vsync and is held until read_req_ack or the ack timeout.
module hdmi_read_req_gen
  import hdmi_frame_pkg::*;
#(
  parameter logic [15:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vout_vsync,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_frame_done,
  output logic             read_req,
  output logic [IDX_W-1:0] read_addr_index,
  input  logic             read_req_ack,
  input  logic             read_done,
  output logic             frame_repeat,
  output logic             frame_skip,
  output logic             req_timeout,
  output logic             busy
);

  logic       vs_rise;

  frm_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  buf_idx_t   addr_q, addr_d;
  buf_idx_t   last_done_q, last_done_d;
  buf_idx_t   prev_issued_q, prev_issued_d;
  logic       issued_q, issued_d;
  logic       frame_valid_q, frame_valid_d;
  logic       frame_repeat_q, frame_repeat_d;
  logic       frame_skip_q, frame_skip_d;
  logic       req_timeout_q, req_timeout_d;
  buf_idx_t   sel_idx;
  logic       have_frame;

  vsync_edge_det u_vs_edge (
    .pclk  (pclk),
    .rst   (rst),
    .vsync (vout_vsync),
    .rise  (vs_rise)
  );

  // A frame completing in the same cycle as the edge is issued directly.
  assign sel_idx    = wr_frame_done ? wr_index : last_done_q;
  assign have_frame = frame_valid_q | wr_frame_done;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    last_done_d    = last_done_q;
    prev_issued_d  = prev_issued_q;
    issued_d       = issued_q;
    frame_valid_d  = frame_valid_q;
    frame_repeat_d = 1'b0;
    frame_skip_d   = 1'b0;
    req_timeout_d  = 1'b0;

    if (wr_frame_done) begin
      last_done_d   = wr_index;
      frame_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (vs_rise && have_frame) begin
          state_d        = ST_REQ;
          cnt_d          = 16'd0;
          addr_d         = sel_idx;
          frame_repeat_d = issued_q && (sel_idx == prev_issued_q);
          prev_issued_d  = sel_idx;
          issued_d       = 1'b1;
        end
      end
      ST_REQ: begin
        frame_skip_d = vs_rise;
        // Ack wins over a timeout landing in the same cycle.
        if (read_req_ack) begin
          state_d = ST_READING;
        end else if (cnt_q == ACK_TIMEOUT - 16'd1) begin
          state_d       = ST_IDLE;
          req_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_READING: begin
        frame_skip_d = vs_rise;
        if (read_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 16'd0;
      addr_q         <= '0;
      last_done_q    <= '0;
      prev_issued_q  <= '0;
      issued_q       <= 1'b0;
      frame_valid_q  <= 1'b0;
      frame_repeat_q <= 1'b0;
      frame_skip_q   <= 1'b0;
      req_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      last_done_q    <= last_done_d;
      prev_issued_q  <= prev_issued_d;
      issued_q       <= issued_d;
      frame_valid_q  <= frame_valid_d;
      frame_repeat_q <= frame_repeat_d;
      frame_skip_q   <= frame_skip_d;
      req_timeout_q  <= req_timeout_d;
    end
  end

  assign read_req        = (state_q == ST_REQ);
  assign busy            = (state_q == ST_REQ) || (state_q == ST_READING);
  assign read_addr_index = addr_q;
  assign frame_repeat    = frame_repeat_q;
  assign frame_skip      = frame_skip_q;
  assign req_timeout     = req_timeout_q;

endmodule

// File: doc/hdmi_read_req_gen.md
HDMI_READ_REQ_GEN -- requirements
Module: hdmi_read_req_gen

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16'd4096: cycles the block waits in REQ for read_req_ack before abandoning the request.
REQ-002 SHALL have port pclk, input, 1: the only clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port vout_vsync, input, 1: display-side vsync, already synchronous to pclk.
REQ-005 SHALL have port wr_index, input, 2: buffer index the writer is currently filling.
REQ-006 SHALL have port wr_frame_done, input, 1: one-cycle pulse; the writer has completed buffer wr_index.
REQ-007 SHALL have port read_req, output, 1: frame read request, level, held until acknowledged.
REQ-008 SHALL have port read_addr_index, output, 2: buffer to read; stable while read_req=1 and in READING.
REQ-009 SHALL have port read_req_ack, input, 1: reader accepts the request.
REQ-010 SHALL have port read_done, input, 1: one-cycle pulse; the reader finished the frame.
REQ-011 SHALL have port frame_repeat, output, 1: one-cycle pulse; the issued buffer equals the previously issued buffer.
REQ-012 SHALL have port frame_skip, output, 1: one-cycle pulse; a vsync edge was ignored because the block was not IDLE.
REQ-013 SHALL have port req_timeout, output, 1: one-cycle pulse; ACK_TIMEOUT expired in REQ.
REQ-014 SHALL have port busy, output, 1: high in REQ or READING.

Function
REQ-015 SHALL detect the vsync rising edge with two registers, vs_d0 and vs_d1: edge = vs_d0 & ~vs_d1.
REQ-016 SHALL hold last_done (2b) and frame_valid; on wr_frame_done, last_done <= wr_index and frame_valid <= 1.
REQ-017 SHALL implement the FSM IDLE -> REQ -> READING -> IDLE.
REQ-018 SHALL move IDLE -> REQ on edge with frame_valid=1, setting read_req=1 and read_addr_index=selected buffer at that same clock edge.
REQ-019 SHALL stay in IDLE on edge with frame_valid=0 and SHALL NOT pulse any output.
REQ-020 SHALL select buffer = wr_index when wr_frame_done and edge occur in the same cycle (bypass), otherwise last_done.
REQ-021 SHALL latch timing so read_req is first high after the pclk edge following the edge that first sampled vout_vsync=1 (2-cycle latency).
REQ-022 SHALL move REQ -> READING on the edge sampling read_req_ack=1, with read_req=0 after that edge.
REQ-023 SHALL ignore read_req_ack outside REQ.
REQ-024 SHALL use a 16b timeout counter, cleared on entering REQ and incremented each cycle in REQ.
REQ-025 SHALL, when the counter reaches ACK_TIMEOUT-1 without ack, go REQ -> IDLE, drive read_req=0, and pulse req_timeout for 1 cycle.
REQ-026 SHALL give ack priority over timeout when both occur in the same cycle.
REQ-027 SHALL move READING -> IDLE on read_done; read_done outside READING SHALL be ignored.
REQ-028 SHALL pulse frame_skip for 1 cycle on any edge in REQ or READING, with no state change.
REQ-029 SHALL pulse frame_repeat with the REQ entry when the selected buffer equals prev_issued (2b, updated on each issue).
REQ-030 SHALL NOT pulse frame_repeat on the first issue after reset.
REQ-031 SHALL wrap indices modulo 4; no other arithmetic on indices.

Reset
REQ-032 SHALL, on rst=1 at a pclk edge, force state=IDLE and clear all of the following to 0: read_req, read_addr_index, frame_repeat, frame_skip, req_timeout, busy, vs_d0, vs_d1, last_done, prev_issued, frame_valid, timeout counter.
REQ-033 SHALL, on reset mid-REQ or mid-READING, drop read_req on that edge with no timeout or skip pulse.

Structure
REQ-034 SHALL place the index width (2), FSM state encoding and default ACK_TIMEOUT in a shared package, hdmi_frame_pkg, also used by the write-side request generator.
REQ-035 SHALL place the vsync edge detector in sub-module vsync_edge_det (pclk, rst, vsync in, rise out) so it is shared with the write side; the rest stays flat.

Verification
REQ-036 SHALL cover: rst, wr_frame_done with wr_index=2, then vsync rise -> read_req=1, read_addr_index=2 two cycles after vsync; ack -> read_req=0 next cycle; read_done -> busy=0.
REQ-037 SHALL cover: vsync rise with no frame written since reset -> read_req stays 0, no pulses.
REQ-038 SHALL cover: wr_frame_done (wr_index=3) coincident with edge while last_done=1 -> read_addr_index=3.
REQ-039 SHALL cover: two vsyncs with no new frame, buffer 1 both times -> second issue pulses frame_repeat; vsync during READING -> frame_skip pulse, state unchanged.
REQ-040 SHALL cover: ACK_TIMEOUT=8, no ack -> read_req high for 8 cycles then 0, req_timeout pulse, IDLE; ack in the 8th cycle -> READING, no timeout pulse.
REQ-041 SHALL cover: rst asserted while in REQ -> read_req=0 after that edge, all outputs 0.
